or1k_wb_boot_loader: RTL and testbench
======================================

# or1k_wb_boot_loader

Wishbone boot master that fills a tile's program memory before its cores run. It sits directly upstream of the `or1k_mpsoc` memory port, on a tile's data bus ahead of the `wb_bfm_memory` RAM. On a start pulse it optionally zero-fills the whole memory, then streams a word sequence from a valid/ready source into consecutive addresses. It holds the CPU reset asserted until loading completes without error, which replaces the simulation-only ELF backdoor with a synthesizable path.

## Interface
- `MEM_SIZE`, `32'h02000000`: memory size in bytes; must be a multiple of 4.
- `BASE_ADDR`, `32'h00000000`: byte address of the first word; must be word-aligned.
- `TIMEOUT`, `16`: maximum cycles a strobe may wait for ack/err; 0 disables the timeout.

Ports:
- `wb_clk_i`  in  1  system clock. One clock domain.
- `wb_rst_i`  in  1  reset, asynchronous and active-high.
- `start_i`  in  1  one-cycle start pulse; honoured only in IDLE, DONE or ERROR.
- `clear_i`  in  1  zero-fill request; sampled together with `start_i`.
- `word_count_i`  in  32  number of words to load; sampled together with `start_i`.
- `ld_data_i`  in  32  load word.
- `ld_valid_i`  in  1  load word valid.
- `ld_ready_o`  out  1  loader accepts a word.
- `wbm_adr_o`  out  32  byte address.
- `wbm_dat_o`  out  32  write data.
- `wbm_sel_o`  out  4  byte selects; always 4'hF during a cycle.
- `wbm_we_o`  out  1  write enable.
- `wbm_cyc_o`  out  1  Wishbone cycle.
- `wbm_stb_o`  out  1  Wishbone strobe.
- `wbm_cti_o`  out  3  cycle type; always 3'b000 (classic).
- `wbm_bte_o`  out  2  burst type; always 2'b00.
- `wbm_ack_i`  in  1  slave acknowledge.
- `wbm_err_i`  in  1  slave error.
- `cpu_rst_o`  out  1  core reset; high except in DONE.
- `busy_o`  out  1  high in CLEAR or LOAD.
- `done_o`  out  1  high in DONE.
- `error_o`  out  1  high in ERROR.

## Operation
- States: IDLE, CLEAR, LOAD, DONE, ERROR. Reset enters IDLE.
- Reset values:
  - `cpu_rst_o` = 1.
  - `ld_ready_o`, `wbm_cyc_o`, `wbm_stb_o`, `wbm_we_o`, `busy_o`, `done_o` and `error_o` = 0.
  - `wbm_adr_o` = `BASE_ADDR`.
  - `wbm_dat_o` = 0.
  - `wbm_sel_o` = 0.
  - All counters = 0.
- On `start_i`:
  - Latch `clear_i` and the count, clamped to `MEM_SIZE/4` (a saturating compare, not truncation).
  - Reset the address to `BASE_ADDR`.
  - Go to CLEAR if `clear_i` is set, otherwise to LOAD.
  - `start_i` is ignored while busy.
- CLEAR:
  - Write 0 to each of `MEM_SIZE/4` words in ascending order.
  - After the last ack, reset the address to `BASE_ADDR` and go to LOAD.
- LOAD with a latched count of 0: go to DONE immediately, with no bus cycles.
- LOAD with a nonzero count:
  - `ld_ready_o` = 1 only while no bus cycle is pending.
  - Each handshake (`ld_valid_i` & `ld_ready_o`) captures the word and launches one single write.
  - Each ack increments the address by 4 and the word counter by 1.
  - After the ack for word `count-1`, go to DONE.
- DONE:
  - `cpu_rst_o` = 0 and `done_o` = 1.
  - Hold until reset or `start_i`; `start_i` reasserts `cpu_rst_o`.
- Error: `wbm_err_i` during a strobe, or a strobe outstanding for `TIMEOUT` cycles, leads to ERROR.
  - In ERROR, drop `cyc`/`stb`, set `error_o` = 1 and keep `cpu_rst_o` = 1.
  - Only `start_i` or reset leaves ERROR.
- Simultaneous `ack` and `err` in the same cycle: err wins.
- Address wrap: not possible, because the count is clamped so that the last address is `BASE_ADDR + MEM_SIZE - 4`.

## Timing
- Handshake at edge E0:
  - `wbm_cyc_o`, `wbm_stb_o` and `wbm_we_o` go high, and address and data become valid, after E0.
  - `ld_ready_o` goes low after E0.
- `cyc`/`stb` are held with stable address and data until the edge that samples `ack`, `err` or the timeout.
- `cyc`/`stb` deassert after that edge. `ld_ready_o` reasserts after the same edge if words remain.
- Throughput with a zero-wait slave: 2 cycles per word in LOAD and 2 cycles per word in CLEAR (strobe, then one idle cycle).
- From `start_i` to the first strobe: 1 cycle in CLEAR; in LOAD, 1 cycle after the first handshake.
- DONE entry, and `cpu_rst_o` deassertion, occur on the edge that samples the final ack.
- Timeout counter:
  - Counts cycles with `stb` high and neither ack nor err.
  - It reaches ERROR on the edge where the count equals `TIMEOUT`.
  - It clears at each new strobe.
- Asynchronous reset mid-cycle: `cyc`/`stb` drop immediately (combinationally from reset) and `cpu_rst_o` rises immediately.

## Test plan
- Load sequence:
  - Stimulus: `clear_i`=0, count 4, data 0x11111111..0x44444444, zero-wait slave.
  - Response: writes to 0x0, 0x4, 0x8, 0xC with `sel`=F; 8 cycles of bus activity; `done_o`=1 and `cpu_rst_o`=0 after the 4th ack.
- Clear then load:
  - Stimulus: `MEM_SIZE`=64, `clear_i`=1, count 2.
  - Response: 16 zero writes to 0x00–0x3C, then 2 data writes at 0x0 and 0x4, then DONE.
- Backpressure:
  - Stimulus: slave acks after 3 wait cycles; `ld_valid_i` toggles each cycle.
  - Response: address and data stable while `stb` is high; no word lost or duplicated; `ld_ready_o` low while `stb` is high.
- Errors:
  - Stimulus A: `wbm_err_i` on word 2.
  - Response A: ERROR, `cpu_rst_o`=1, no further strobes.
  - Stimulus B: a slave that never acks, with `TIMEOUT`=16.
  - Response B: ERROR exactly 16 cycles after `stb` rises.
  - Stimulus C: `start_i` from ERROR.
  - Response C: reload from `BASE_ADDR`.
- Boundaries:
  - Stimulus: count 0; count 0xFFFFFFFF with `MEM_SIZE`=32; `start_i` mid-LOAD.
  - Response: immediate DONE; exactly 8 writes ending at 0x1C; the mid-LOAD start is ignored.
- Async reset:
  - Stimulus: assert `wb_rst_i` while `stb` is high.
  - Response: `cyc`/`stb` low and `cpu_rst_o` high in the same cycle; IDLE after release.

Source files
------------

// File: rtl/or1k_wb_boot_loader.sv
// -----------------------------------------------------------------------------
// or1k_wb_boot_loader
//
// Wishbone boot master that fills a tile's program memory before its cores run.
// A start pulse can zero-fill the whole memory first. It then streams words
// from a valid/ready source into consecutive word addresses starting at
// BASE_ADDR. The core reset stays asserted until a load has completed without
// a bus error or timeout.
//
// Parameters
//   MEM_SIZE   memory size in bytes (multiple of 4)
//   BASE_ADDR  byte address of the first word (word aligned)
//   TIMEOUT    cycles a strobe may wait for ack/err; 0 disables the timeout
//
// Ports
//   wb_clk_i, wb_rst_i       clock, asynchronous active-high reset
//   start_i                  start pulse (taken in IDLE, DONE or ERROR)
//   clear_i, word_count_i    zero-fill request and word count, read with start_i
//   ld_data_i, ld_valid_i,
//   ld_ready_o               load word stream (valid/ready)
//   wbm_*                    classic single-write Wishbone master
//   cpu_rst_o                core reset, low only in DONE
//   busy_o, done_o, error_o  status
// -----------------------------------------------------------------------------
module or1k_wb_boot_loader #(
    parameter logic [31:0] MEM_SIZE  = 32'h02000000,
    parameter logic [31:0] BASE_ADDR = 32'h00000000,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        start_i,
    input  logic        clear_i,
    input  logic [31:0] word_count_i,
    input  logic [31:0] ld_data_i,
    input  logic        ld_valid_i,
    output logic        ld_ready_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    output logic        wbm_we_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic [2:0]  wbm_cti_o,
    output logic [1:0]  wbm_bte_o,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    output logic        cpu_rst_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [31:0] MEM_WORDS = MEM_SIZE >> 2;
    // Timeout fires on the edge where the wait count would reach TIMEOUT.
    localparam logic [31:0] TO_LAST   = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

    state_t      state_q;
    logic [31:0] adr_q;
    logic [31:0] dat_q;
    logic [3:0]  sel_q;
    logic        cyc_q;
    logic        we_q;
    logic        ready_q;
    logic        cpu_rst_q;
    logic [31:0] cnt_q;     // words acknowledged in the current phase
    logic [31:0] total_q;   // clamped load count
    logic [31:0] to_q;      // wait cycles of the current strobe

    logic [31:0] adr_d;
    logic [31:0] cnt_d;
    logic [31:0] count_d;
    logic        timeout_hit;

    assign adr_d   = adr_q + 32'd4;
    assign cnt_d   = cnt_q + 32'd1;
    // Saturating clamp keeps the last address at BASE_ADDR + MEM_SIZE - 4.
    assign count_d = (word_count_i > MEM_WORDS) ? MEM_WORDS : word_count_i;

    assign timeout_hit = (TIMEOUT != 0) && cyc_q && !wbm_ack_i && !wbm_err_i
                         && (to_q == TO_LAST);

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q   <= S_IDLE;
            adr_q     <= BASE_ADDR;
            dat_q     <= 32'd0;
            sel_q     <= 4'h0;
            cyc_q     <= 1'b0;
            we_q      <= 1'b0;
            ready_q   <= 1'b0;
            cpu_rst_q <= 1'b1;
            cnt_q     <= 32'd0;
            total_q   <= 32'd0;
            to_q      <= 32'd0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start_i) begin
                        total_q   <= count_d;
                        adr_q     <= BASE_ADDR;
                        cnt_q     <= 32'd0;
                        to_q      <= 32'd0;
                        cpu_rst_q <= 1'b1;
                        if (clear_i) begin
                            // First zero write goes out right after the start edge.
                            state_q <= S_CLEAR;
                            cyc_q   <= 1'b1;
                            we_q    <= 1'b1;
                            sel_q   <= 4'hF;
                            dat_q   <= 32'd0;
                        end else begin
                            state_q <= S_LOAD;
                            ready_q <= (count_d != 32'd0);
                        end
                    end
                end

                S_CLEAR: begin
                    if (cyc_q) begin
                        if (wbm_err_i || timeout_hit) begin
                            state_q <= S_ERROR;
                            cyc_q   <= 1'b0;
                            we_q    <= 1'b0;
                            sel_q   <= 4'h0;
                        end else if (wbm_ack_i) begin
                            cyc_q <= 1'b0;
                            we_q  <= 1'b0;
                            sel_q <= 4'h0;
                            if (cnt_q == MEM_WORDS - 32'd1) begin
                                state_q <= S_LOAD;
                                adr_q   <= BASE_ADDR;
                                cnt_q   <= 32'd0;
                                ready_q <= (total_q != 32'd0);
                            end else begin
                                adr_q <= adr_d;
                                cnt_q <= cnt_d;
                            end
                        end else begin
                            to_q <= to_q + 32'd1;
                        end
                    end else begin
                        // Idle cycle between zero writes: launch the next one.
                        cyc_q <= 1'b1;
                        we_q  <= 1'b1;
                        sel_q <= 4'hF;
                        dat_q <= 32'd0;
                        to_q  <= 32'd0;
                    end
                end

                S_LOAD: begin
                    if (total_q == 32'd0) begin
                        state_q   <= S_DONE;
                        cpu_rst_q <= 1'b0;
                    end else if (cyc_q) begin
                        if (wbm_err_i || timeout_hit) begin
                            state_q <= S_ERROR;
                            cyc_q   <= 1'b0;
                            we_q    <= 1'b0;
                            sel_q   <= 4'h0;
                            ready_q <= 1'b0;
                        end else if (wbm_ack_i) begin
                            cyc_q <= 1'b0;
                            we_q  <= 1'b0;
                            sel_q <= 4'h0;
                            adr_q <= adr_d;
                            cnt_q <= cnt_d;
                            if (cnt_d == total_q) begin
                                state_q   <= S_DONE;
                                cpu_rst_q <= 1'b0;
                                ready_q   <= 1'b0;
                            end else begin
                                ready_q <= 1'b1;
                            end
                        end else begin
                            to_q <= to_q + 32'd1;
                        end
                    end else if (ready_q && ld_valid_i) begin
                        // Handshake: capture the word and start its single write.
                        dat_q   <= ld_data_i;
                        cyc_q   <= 1'b1;
                        we_q    <= 1'b1;
                        sel_q   <= 4'hF;
                        ready_q <= 1'b0;
                        to_q    <= 32'd0;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    cyc_q   <= 1'b0;
                    we_q    <= 1'b0;
                    sel_q   <= 4'h0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign ld_ready_o = ready_q;
    assign wbm_adr_o  = adr_q;
    assign wbm_dat_o  = dat_q;
    assign wbm_sel_o  = sel_q;
    assign wbm_we_o   = we_q;
    assign wbm_cyc_o  = cyc_q;
    assign wbm_stb_o  = cyc_q;
    assign wbm_cti_o  = 3'b000;
    assign wbm_bte_o  = 2'b00;
    assign cpu_rst_o  = cpu_rst_q;
    assign busy_o     = (state_q == S_CLEAR) || (state_q == S_LOAD);
    assign done_o     = (state_q == S_DONE);
    assign error_o    = (state_q == S_ERROR);

endmodule

// File: tb/tb_or1k_wb_boot_loader.sv
module tb_or1k_wb_boot_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        clear = 1'b0;
    logic [31:0] count = 32'd0;
    logic [31:0] ld_data_i;
    logic        ld_valid_i;
    logic        ld_ready_o;
    logic [31:0] wbm_adr_o, wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic        wbm_we_o, wbm_cyc_o, wbm_stb_o;
    logic [2:0]  wbm_cti_o;
    logic [1:0]  wbm_bte_o;
    logic        wbm_ack_i, wbm_err_i;
    logic        cpu_rst_o, busy_o, done_o, error_o;

    always #5 clk = ~clk;

    or1k_wb_boot_loader #(.MEM_SIZE(32'd64), .BASE_ADDR(32'h0), .TIMEOUT(16)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start), .clear_i(clear),
        .word_count_i(count), .ld_data_i(ld_data_i), .ld_valid_i(ld_valid_i),
        .ld_ready_o(ld_ready_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
        .wbm_sel_o(wbm_sel_o), .wbm_we_o(wbm_we_o), .wbm_cyc_o(wbm_cyc_o),
        .wbm_stb_o(wbm_stb_o), .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o),
        .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i), .cpu_rst_o(cpu_rst_o),
        .busy_o(busy_o), .done_o(done_o), .error_o(error_o)
    );

    // Second instance with a 32-byte memory for the count clamp boundary.
    logic        start32 = 1'b0;
    logic        rdy32, we32, cyc32, stb32, ack32, crst32, busy32, done32, err32;
    logic [31:0] adr32, dat32;
    logic [3:0]  sel32;
    logic [2:0]  cti32;
    logic [1:0]  bte32;
    assign ack32 = cyc32 & stb32;

    or1k_wb_boot_loader #(.MEM_SIZE(32'd32), .BASE_ADDR(32'h0), .TIMEOUT(16)) u32 (
        .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start32), .clear_i(1'b0),
        .word_count_i(32'hFFFFFFFF), .ld_data_i(32'hA5A5A5A5), .ld_valid_i(1'b1),
        .ld_ready_o(rdy32), .wbm_adr_o(adr32), .wbm_dat_o(dat32),
        .wbm_sel_o(sel32), .wbm_we_o(we32), .wbm_cyc_o(cyc32),
        .wbm_stb_o(stb32), .wbm_cti_o(cti32), .wbm_bte_o(bte32),
        .wbm_ack_i(ack32), .wbm_err_i(1'b0), .cpu_rst_o(crst32),
        .busy_o(busy32), .done_o(done32), .error_o(err32)
    );

    int          n32 = 0;
    logic [31:0] last32 = 32'd0;
    always @(negedge clk) begin
        if (cyc32 && ack32) begin
            n32    <= n32 + 1;
            last32 <= adr32;
        end
    end

    // ---------------- slave and source models ----------------
    int  wait_n = 0;
    bit  never_ack = 1'b0;
    bit  err_en = 1'b0;
    bit  both = 1'b0;
    int  err_at = 0;
    bit  tog_mode = 1'b0;
    int  wcnt = 0;
    int  src_k = 0;
    bit  tog = 1'b0;
    logic hit;

    function automatic logic [31:0] pat(input int k);
        logic [31:0] t;
        t = 32'(k + 1);
        return t * 32'h11111111;
    endfunction

    logic [31:0] adr_log [0:255];
    logic [31:0] dat_log [0:255];
    int nwr = 0;
    int nstb = 0;
    int viol = 0;
    bit stb_prev = 1'b0;
    bit held = 1'b0;
    logic [31:0] held_adr = 32'd0, held_dat = 32'd0;

    assign hit        = wbm_cyc_o && wbm_stb_o && (wcnt == wait_n) && !never_ack;
    assign wbm_err_i  = hit && err_en && (nwr == err_at);
    assign wbm_ack_i  = hit && (!wbm_err_i || both);
    assign ld_valid_i = tog_mode ? tog : 1'b1;
    assign ld_data_i  = pat(src_k);

    always @(posedge clk) begin
        if (wbm_cyc_o && wbm_stb_o && !wbm_ack_i && !wbm_err_i) wcnt <= wcnt + 1;
        else wcnt <= 0;
        if (ld_valid_i && ld_ready_o) src_k <= src_k + 1;
        tog <= ~tog;
    end

    // Bus monitor: write log, strobe count, protocol violations.
    always @(negedge clk) begin
        stb_prev <= wbm_stb_o;
        if (wbm_stb_o && !stb_prev) nstb <= nstb + 1;
        if (wbm_cyc_o && wbm_stb_o && wbm_ack_i && !wbm_err_i) begin
            if (nwr < 256) begin
                adr_log[nwr] <= wbm_adr_o;
                dat_log[nwr] <= wbm_dat_o;
            end
            nwr <= nwr + 1;
        end
        if (!rst && ((held && !error_o && (!wbm_stb_o || wbm_adr_o != held_adr || wbm_dat_o != held_dat))
                     || (wbm_stb_o && (ld_ready_o || wbm_sel_o != 4'hF || !wbm_we_o || !wbm_cyc_o))
                     || wbm_cti_o != 3'b000 || wbm_bte_o != 2'b00))
            viol <= viol + 1;
        held     <= !rst && wbm_stb_o && !wbm_ack_i && !wbm_err_i;
        held_adr <= wbm_adr_o;
        held_dat <= wbm_dat_o;
    end

    // ---------------- checking helpers ----------------
    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic do_start(input bit c, input logic [31:0] n);
        @(negedge clk);
        clear = c;
        count = n;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_end(output int lat);
        lat = 0;
        while (!(done_o || error_o) && lat < 3000) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic wait_stb(output int k);
        k = 0;
        while (!wbm_stb_o && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
    endtask

    // Check logged writes [base, base+n): optional 16 zero writes, then load words.
    task automatic chk_writes(input string name, input int base, input int n,
                              input bit clr, input int sbase);
        int errs;
        int k;
        logic [31:0] ea, ed;
        errs = 0;
        for (int j = 0; j < n; j++) begin
            if (clr && j < 16) begin
                ea = 32'(4 * j);
                ed = 32'd0;
            end else begin
                k  = clr ? j - 16 : j;
                ea = 32'(4 * k);
                ed = pat(sbase + k);
            end
            if (adr_log[base + j] !== ea || dat_log[base + j] !== ed) errs++;
        end
        chk(name, 32'(errs), 32'd0);
    endtask

    typedef struct {
        string       name;
        bit          clr;
        logic [31:0] cnt;
        int          wt;
        bit          tg;
        int          exp_wr;
        int          exp_lat;
    } vec_t;

    vec_t vecs [0:5];

    initial begin
        int lat, base, sb, v0, s0, k, n;

        vecs[0] = '{"load4",     1'b0, 32'd4,          0, 1'b0, 4,  8};
        vecs[1] = '{"clr_load2", 1'b1, 32'd2,          0, 1'b0, 18, 35};
        vecs[2] = '{"count0",    1'b0, 32'd0,          0, 1'b0, 0,  1};
        vecs[3] = '{"count_max", 1'b0, 32'hFFFFFFFF,   0, 1'b0, 16, 32};
        vecs[4] = '{"count17",   1'b0, 32'd17,         0, 1'b0, 16, 32};
        vecs[5] = '{"backpress", 1'b0, 32'd3,          3, 1'b1, 3,  -1};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cpu_rst", {31'd0, cpu_rst_o}, 32'd1);
        chk("rst_ready",   {31'd0, ld_ready_o}, 32'd0);
        chk("rst_cyc",     {31'd0, wbm_cyc_o}, 32'd0);
        chk("rst_stb",     {31'd0, wbm_stb_o}, 32'd0);
        chk("rst_we",      {31'd0, wbm_we_o}, 32'd0);
        chk("rst_adr",     wbm_adr_o, 32'd0);
        chk("rst_dat",     wbm_dat_o, 32'd0);
        chk("rst_sel",     {28'd0, wbm_sel_o}, 32'd0);
        chk("rst_status",  {29'd0, busy_o, done_o, error_o}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_status", {29'd0, busy_o, done_o, error_o}, 32'd0);

        // Table-driven load scenarios
        for (int i = 0; i < 6; i++) begin
            wait_n   = vecs[i].wt;
            tog_mode = vecs[i].tg;
            base = nwr;
            sb   = src_k;
            v0   = viol;
            do_start(vecs[i].clr, vecs[i].cnt);
            chk({vecs[i].name, "_start_rst"}, {30'd0, cpu_rst_o, done_o}, 32'd2);
            wait_end(lat);
            if (vecs[i].exp_lat >= 0) chk({vecs[i].name, "_latency"}, 32'(lat), 32'(vecs[i].exp_lat));
            chk({vecs[i].name, "_done"},    {30'd0, done_o, error_o}, 32'd2);
            chk({vecs[i].name, "_cpu_rst"}, {31'd0, cpu_rst_o}, 32'd0);
            chk({vecs[i].name, "_nwr"},     32'(nwr - base), 32'(vecs[i].exp_wr));
            chk_writes({vecs[i].name, "_writes"}, base, vecs[i].exp_wr, vecs[i].clr, sb);
            chk({vecs[i].name, "_proto"},   32'(viol - v0), 32'd0);
        end
        wait_n   = 0;
        tog_mode = 1'b0;

        // Error A: err (with a simultaneous ack) on word 2
        base   = nwr;
        err_at = nwr + 2;
        err_en = 1'b1;
        both   = 1'b1;
        do_start(1'b0, 32'd4);
        wait_end(lat);
        chk("errA_state",   {30'd0, done_o, error_o}, 32'd1);
        chk("errA_cpu_rst", {31'd0, cpu_rst_o}, 32'd1);
        chk("errA_cyc",     {30'd0, wbm_cyc_o, wbm_stb_o}, 32'd0);
        chk("errA_nwr",     32'(nwr - base), 32'd2);
        err_en = 1'b0;
        both   = 1'b0;
        s0 = nstb;
        repeat (10) @(posedge clk);
        #1;
        chk("errA_no_stb",  32'(nstb - s0), 32'd0);
        chk("errA_hold",    {31'd0, error_o}, 32'd1);

        // Error C: restart from ERROR reloads from the base address
        base = nwr;
        sb   = src_k;
        do_start(1'b0, 32'd2);
        wait_end(lat);
        chk("errC_done", {30'd0, done_o, error_o}, 32'd2);
        chk("errC_nwr",  32'(nwr - base), 32'd2);
        chk_writes("errC_writes", base, 2, 1'b0, sb);

        // Error B: slave never acks, timeout after 16 strobe cycles
        never_ack = 1'b1;
        do_start(1'b0, 32'd1);
        wait_stb(k);
        chk("toB_stb_seen", {31'd0, wbm_stb_o}, 32'd1);
        n = 0;
        while (!error_o && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("toB_cycles",  32'(n), 32'd16);
        chk("toB_cyc",     {31'd0, wbm_cyc_o}, 32'd0);
        chk("toB_cpu_rst", {31'd0, cpu_rst_o}, 32'd1);
        never_ack = 1'b0;

        // start_i while loading is ignored
        wait_n   = 3;
        tog_mode = 1'b1;
        base = nwr;
        sb   = src_k;
        v0   = viol;
        do_start(1'b0, 32'd3);
        repeat (4) @(posedge clk);
        do_start(1'b1, 32'd1);
        chk("mid_busy", {31'd0, busy_o}, 32'd1);
        wait_end(lat);
        chk("mid_done",  {30'd0, done_o, error_o}, 32'd2);
        chk("mid_nwr",   32'(nwr - base), 32'd3);
        chk_writes("mid_writes", base, 3, 1'b0, sb);
        chk("mid_proto", 32'(viol - v0), 32'd0);
        wait_n   = 0;
        tog_mode = 1'b0;

        // Asynchronous reset while a strobe is outstanding
        never_ack = 1'b1;
        do_start(1'b0, 32'd2);
        wait_stb(k);
        chk("arst_stb_before", {31'd0, wbm_stb_o}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_cyc_stb", {30'd0, wbm_cyc_o, wbm_stb_o}, 32'd0);
        chk("arst_cpu_rst", {31'd0, cpu_rst_o}, 32'd1);
        never_ack = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("arst_idle", {28'd0, busy_o, done_o, error_o, ld_ready_o}, 32'd0);
        chk("arst_adr",  wbm_adr_o, 32'd0);

        // Clamp on a 32-byte memory: exactly 8 writes ending at 0x1C
        @(negedge clk);
        start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        k = 0;
        while (!done32 && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("clamp32_done", {30'd0, done32, crst32}, 32'd2);
        chk("clamp32_nwr",  32'(n32), 32'd8);
        chk("clamp32_last", last32, 32'h1C);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
